md_ctrl: RTL and testbench

- Controller and owner of the multiply/divide resource and the HI/LO registers in the P5 pipeline.
- Accepts one mult/div/mthi/mtlo command per cycle from the EX stage, using the ID/EX outputs MultDivStart, MultDivOp, HiLoWe and HiLo.
- Sequences each operation over a fixed multi-cycle latency.
- Produces the stall that freezes PC and IF/ID and drives ID/EX en=0 (bubble) while an HI/LO-dependent instruction waits in ID.

---
 rtl/md_pkg.sv | 18 +
 rtl/md_arith.sv | 57 +++++
 rtl/md_ctrl.sv | 97 +++++++++
 tb/tb_md_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide controller (md_ctrl, md_arith).
// Optional stall counter in md_ctrl is enabled with MD_STALL_CNT_EN.
package md_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  localparam int CNT_W = 4;

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div datapath working on the operands latched at issue.
// div0 tells the controller to keep HI/LO untouched.
module md_arith
  import md_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic               ovf;

  assign div0   = (b == 32'd0);
  // Substitute a harmless divisor so the dividers never see zero.
  assign b_safe = div0 ? 32'd1 : b;
  assign ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  always_comb begin
    quot_s = 32'sd0;
    rem_s  = 32'sd0;
    if (ovf) begin
      quot_s = $signed(a);
      rem_s  = 32'sd0;
    end else begin
      quot_s = $signed(a) / $signed(b_safe);
      rem_s  = $signed(a) % $signed(b_safe);
    end
  end

  assign quot_u = a / b_safe;
  assign rem_u  = a % b_safe;

  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      MD_MULT:  begin hi_res = prod_s[63:32];   lo_res = prod_s[31:0];    end
      MD_MULTU: begin hi_res = prod_u[63:32];   lo_res = prod_u[31:0];    end
      MD_DIV:   begin hi_res = $unsigned(rem_s); lo_res = $unsigned(quot_s); end
      default:  begin hi_res = rem_u;           lo_res = quot_u;          end
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences fixed-latency ops, and raises the pipeline stall.
// Define MD_STALL_CNT_EN to add the saturating stall_cnt output.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic [31:0] wdata,
  input  logic        id_uses_md,
  output logic        busy,
  output logic        stall,
`ifdef MD_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [1:0]       op_q;
  logic [31:0]      hi_res;
  logic [31:0]      lo_res;
  logic             div0;

  md_arith u_arith (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  // Busy already in the issue cycle so a dependent instruction in ID stalls at once.
  assign busy  = start | (state == RUN);
  assign stall = id_uses_md & busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cnt   <= op[1] ? DIV_CNT : MULT_CNT;
            state <= RUN;
          end else if (hilo_we) begin
            if (hilo_sel) hi <= wdata;
            else          lo <= wdata;
          end
        end
        default: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            if (!(op_q[1] && div0)) begin
              hi <= hi_res;
              lo <= lo_res;
            end
          end
        end
      endcase
    end
  end

`ifdef MD_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))   stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: vector table of mult/div ops plus hand sequences
// for mthi/mtlo, divide by zero, back-to-back issue and mid-operation reset.
module tb_md_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hilo_we = 1'b0;
  logic        hilo_sel = 1'b0;
  logic [31:0] wdata = '0;
  logic        id_uses_md = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  md_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hilo_we    (hilo_we),
    .hilo_sel   (hilo_sel),
    .wdata      (wdata),
    .id_uses_md (id_uses_md),
    .busy       (busy),
    .stall      (stall),
`ifdef MD_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) assert (!(start && hilo_we)) else $error("start and hilo_we together");
  end

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] m_sc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Issue in cycle 0, then walk the RUN cycles; operands are scrambled after issue.
  task automatic issue_and_wait(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                                input logic id, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    lat = o[1] ? DIV_LAT : MULT_LAT;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb; id_uses_md = id;
    #1;
    check("busy_issue", {31'd0, busy}, 32'd1);
    check("stall_issue", {31'd0, stall}, {31'd0, id});
    check("hi_issue", hi, m_hi);
    check("lo_issue", lo, m_lo);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      #1;
      check("busy_run", {31'd0, busy}, 32'd1);
      check("stall_run", {31'd0, stall}, {31'd0, id});
      check("hi_run", hi, m_hi);
      check("lo_run", lo, m_lo);
    end
    m_hi = eh;
    m_lo = el;
    if (id) m_sc = m_sc + 32'(lat + 1);
  endtask

  task automatic finish_check();
    @(negedge clk);
    #1;
    check("busy_done", {31'd0, busy}, 32'd0);
    check("stall_done", {31'd0, stall}, 32'd0);
    check("hi_done", hi, m_hi);
    check("lo_done", lo, m_lo);
`ifdef MD_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_sc);
`endif
    id_uses_md = 1'b0;
  endtask

  task automatic move_to(input logic sel, input logic [31:0] d);
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = sel; wdata = d;
    #1;
    check("mt_busy", {31'd0, busy}, 32'd0);
    check("mt_nobypass", sel ? hi : lo, sel ? m_hi : m_lo);
    @(negedge clk);
    hilo_we = 1'b0;
    if (sel) m_hi = d; else m_lo = d;
    #1;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        id;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'h0000_0007, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'h0000_0003};
    vecs[4] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 1'b1, 32'h0000_0001, 32'h2345_6780};
    vecs[5] = '{2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0, 32'h0000_0002, 32'hFFFF_FFF2};
    vecs[6] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[7] = '{2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0, 32'h0000_0000, 32'h0000_000F};
    vecs[8] = '{2'b00, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[9] = '{2'b01, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h0000_0000, 32'h8000_0000};

    // Reset state, including stall held off while idle with a dependent instruction in ID.
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    id_uses_md = 1'b1;
    #1;
    check("idle_stall", {31'd0, stall}, 32'd0);
`ifdef MD_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    id_uses_md = 1'b0;

    foreach (vecs[i]) begin
      issue_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].id, vecs[i].hi, vecs[i].lo);
      finish_check();
    end

    // Divide by zero after mtlo/mthi: full latency, HI/LO untouched.
    move_to(1'b0, 32'h0000_1234);
    move_to(1'b1, 32'h0000_ABCD);
    issue_and_wait(2'b10, 32'h0000_0055, 32'h0000_0000, 1'b1, 32'h0000_ABCD, 32'h0000_1234);
    finish_check();
    issue_and_wait(2'b11, 32'h0000_0055, 32'h0000_0000, 1'b0, 32'h0000_ABCD, 32'h0000_1234);
    finish_check();

    // Back-to-back: second issue lands in the cycle right after the commit edge.
    issue_and_wait(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000);
    issue_and_wait(2'b11, 32'h0000_0064, 32'h0000_0007, 1'b1, 32'h0000_0002, 32'h0000_000E);
    finish_check();

    // Reset in cycle 3 of a div abandons it with no late commit.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0; m_sc = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd0);

    // Operation after reset still works.
    issue_and_wait(2'b00, 32'h0000_0003, 32'h0000_0007, 1'b1, 32'h0000_0000, 32'h0000_0015);
    finish_check();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
